// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and constants for the sequential multiplier
package mult_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] ITER_LAST = 5'd31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/negate_32.sv
// rtl/negate_32.sv - 32-bit ~a + cin slice for two's-complement negation (SIGNED_MULT_EN only)
`ifdef SIGNED_MULT_EN
module negate_32 (
    input  logic [31:0] i_a,
    input  logic        i_cin,
    output logic [31:0] o_y,
    output logic        o_cout
);

    logic [31:0] w_inv;

    not_gate_32 u_not (
        .i_a (i_a),
        .o_y (w_inv)
    );

    // Incrementer; the carry out lets two slices chain into a 64-bit negation
    assign {o_cout, o_y} = {1'b0, w_inv} + {32'b0, i_cin};

endmodule
`endif

// File: rtl/not_gate_32.sv
// rtl/not_gate_32.sv - 32-bit bitwise-NOT stage (built only with SIGNED_MULT_EN)
`ifdef SIGNED_MULT_EN
module not_gate_32 (
    input  logic [31:0] i_a,
    output logic [31:0] o_y
);

    // Plain inversion, shared with the ALU logic stages
    assign o_y = ~i_a;

endmodule
`endif

// File: rtl/mult_seq_32.sv
// rtl/mult_seq_32.sv - sequential 32x32 shift-add multiplier; SIGNED_MULT_EN selects the signed build
module mult_seq_32
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [2*WIDTH:0]       r_acc;
    logic [2*WIDTH:0]       w_acc_calc;
    logic [WIDTH:0]         w_sum;
    logic [WIDTH-1:0]       r_mcand;
    logic [WIDTH-1:0]       w_mcand_in;
    logic [WIDTH-1:0]       w_mplier_in;
    logic [CNT_W-1:0]       r_cnt;
    logic [2*WIDTH-1:0]     r_product;
    logic                   w_last;

`ifdef SIGNED_MULT_EN
    logic                   r_sign;
    logic [WIDTH-1:0]       w_neg_a;
    logic [WIDTH-1:0]       w_neg_b;
    logic [WIDTH-1:0]       w_neg_lo;
    logic [WIDTH-1:0]       w_neg_hi;
    logic                   w_carry_lo;
    logic                   w_unused_cout_a;
    logic                   w_unused_cout_b;
    logic                   w_unused_cout_hi;
    logic [2*WIDTH-1:0]     w_fix_res;

    negate_32 u_neg_a (
        .i_a    (a),
        .i_cin  (1'b1),
        .o_y    (w_neg_a),
        .o_cout (w_unused_cout_a)
    );

    negate_32 u_neg_b (
        .i_a    (b),
        .i_cin  (1'b1),
        .o_y    (w_neg_b),
        .o_cout (w_unused_cout_b)
    );

    // Low half adds the +1; its carry ripples into the high half
    negate_32 u_neg_res_lo (
        .i_a    (r_acc[WIDTH-1:0]),
        .i_cin  (1'b1),
        .o_y    (w_neg_lo),
        .o_cout (w_carry_lo)
    );

    negate_32 u_neg_res_hi (
        .i_a    (r_acc[2*WIDTH-1:WIDTH]),
        .i_cin  (w_carry_lo),
        .o_y    (w_neg_hi),
        .o_cout (w_unused_cout_hi)
    );

    // Magnitudes go into the unsigned core; 0x80000000 maps to itself, which is the right magnitude
    always_comb begin
        w_mcand_in  = a[WIDTH-1] ? w_neg_a : a;
        w_mplier_in = b[WIDTH-1] ? w_neg_b : b;
        w_fix_res   = r_sign ? {w_neg_hi, w_neg_lo} : r_acc[2*WIDTH-1:0];
    end
`else
    // Unsigned build feeds operands straight through
    always_comb begin
        w_mcand_in  = a;
        w_mplier_in = b;
    end
`endif

    // One shift-add step: conditional 33-bit add into the upper half, then shift right
    always_comb begin
        w_sum      = r_acc[0] ? (r_acc[2*WIDTH:WIDTH] + {1'b0, r_mcand}) : r_acc[2*WIDTH:WIDTH];
        w_acc_calc = {1'b0, w_sum, r_acc[WIDTH-1:1]};
        w_last     = (r_cnt == ITER_LAST);
    end

    // Next-state logic and status outputs decoded from the state
    always_comb begin
        w_state_nxt = r_state;
        busy        = (r_state != IDLE);
        done        = (r_state == DONE);
        case (r_state)
            IDLE: if (start) w_state_nxt = CALC;
`ifdef SIGNED_MULT_EN
            CALC: if (w_last) w_state_nxt = FIX;
            FIX:  w_state_nxt = DONE;
`else
            CALC: if (w_last) w_state_nxt = DONE;
`endif
            DONE: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, accumulator, counter and product registers; product loads on entry to DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_cnt     <= '0;
            r_product <= '0;
`ifdef SIGNED_MULT_EN
            r_sign    <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_mcand <= w_mcand_in;
                        r_acc   <= {{(WIDTH+1){1'b0}}, w_mplier_in};
                        r_cnt   <= '0;
`ifdef SIGNED_MULT_EN
                        r_sign  <= a[WIDTH-1] ^ b[WIDTH-1];
`endif
                    end
                end
                CALC: begin
                    r_acc <= w_acc_calc;
                    r_cnt <= r_cnt + 1'b1;
`ifndef SIGNED_MULT_EN
                    if (w_last) r_product <= w_acc_calc[2*WIDTH-1:0];
`endif
                end
`ifdef SIGNED_MULT_EN
                FIX: begin
                    r_acc     <= {1'b0, w_fix_res};
                    r_product <= w_fix_res;
                end
`endif
                default: ;
            endcase
        end
    end

    assign product = r_product;

endmodule

// File: doc/mult_seq_32.md
# mult_seq_32

- Sequential 32x32 shift-add multiplier producing a 64-bit product over 32 iterations.
- Sits in the ALU datapath beside the 32-bit logic stages.
- In its signed build it consumes the bitwise-NOT stage to form two's-complement negations of its operands and its result.
- Presents a start/busy/done handshake to the ALU control unit.

## Interface
Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH (only 32 is verified)

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only when not busy
- a  input  32  multiplicand, sampled on accepted start
- b  input  32  multiplier, sampled on accepted start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse, product valid
- product  output  64  result; holds until next done

One clock; reset is asynchronous and active-low.

## Operation
- FSM states: IDLE, CALC, FIX (only when SIGNED_MULT_EN is defined), DONE.
- Reset values: state=IDLE, busy=0, done=0, product=0, iteration counter=0, accumulator=0.
- IDLE:
  - start=1 latches the operands and moves to CALC.
  - The accumulator is loaded as acc[64:0] = {33'b0, mplier}.
  - The counter is set to 0.
- CALC, once per cycle:
  - If acc[0]=1, acc[64:32] = acc[63:32] + mcand, a 33-bit add with the carry kept.
  - Then acc shifts right by 1.
  - The counter increments.
  - After the 32nd iteration (counter==31 on entry), go to FIX or DONE.
- FIX (signed build only):
  - If the sign flag is set, acc[63:0] = ~acc[63:0] + 1.
  - Next state is DONE.
- DONE:
  - product <= acc[63:0].
  - done=1 for exactly this cycle.
  - Next state is IDLE.
- busy=1 in CALC, FIX and DONE; busy=0 in IDLE.
- start while busy is ignored. There is no queueing, and the latched operands are unchanged.
- A start in the IDLE cycle immediately after DONE is accepted, so back-to-back operations need one gap cycle.
- product changes only on the DONE cycle; otherwise it holds its previous value.
- Reset asserted mid-operation: all state clears immediately and product returns to 0. An operation in flight produces no done pulse.

## Timing
- Start accepted at edge 0.
- CALC occupies cycles 1..32.
- Unsigned build: done high in cycle 33, and product is valid from the edge ending cycle 32.
- Signed build: FIX is cycle 33 and done is high in cycle 34.
- Throughput is one operation per 34 (unsigned) or 35 (signed) cycles, including the IDLE gap.

## Configuration
The build is selected by the SIGNED_MULT_EN macro.

Defined (signed build):
- Operands are two's-complement.
- At start, mcand = a[31] ? ~a+1 : a and mplier = b[31] ? ~b+1 : b.
- sign flag = a[31]^b[31].
- FIX negates the 64-bit result when the sign flag is set.
- 0x80000000 has magnitude 0x80000000, which is treated as an unsigned 32-bit value in CALC and is correct.
- A zero product with the sign flag set stays 0.

Undefined (unsigned build):
- Operands are unsigned.
- No negation logic and no FIX state.

## Structure
- Package mult_pkg:
  - state enum (IDLE, CALC, FIX, DONE)
  - WIDTH=32, CNT_W=5
  - ITER_LAST=31
- One sub-module, negate_32:
  - Built from not_gate_32 plus a +1 incrementer.
  - Instantiated twice for the operands.
  - For the 64-bit result: two instances, with the carry from the low half's increment into the high half.
  - Present only under SIGNED_MULT_EN.
- The FSM and accumulator datapath live in mult_seq_32 itself.

## Test plan
- Unsigned, a=3, b=5, start at edge 0: busy high in cycles 1..33, done pulses only in cycle 33, product=64'h0000_0000_0000_000F, done is one cycle wide.
- Unsigned, a=b=32'hFFFF_FFFF: product=64'hFFFF_FFFE_0000_0001. Then a=0, b=32'h1234_5678: product=0.
- Signed build:
  - a=-3 (32'hFFFF_FFFD), b=5: product=64'hFFFF_FFFF_FFFF_FFF1, done in cycle 34.
  - a=b=32'h8000_0000: product=64'h4000_0000_0000_0000.
  - a=-7, b=0: product=0.
- Start pulsed at cycle 10 with new a=9, b=9 while busy on 2*4: ignored, product=8. Then start in the IDLE cycle after done with a=9, b=9 gives 81.
- rst_n low at cycle 15 of an operation:
  - busy, done and product are 0 asynchronously.
  - No done pulse.
  - After release, a=6, b=7 gives 42.
